ahb_slave_if: RTL and testbench
===============================

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

Interface
REQ-001 SHALL have port hclk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port hresetn, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port hwrite, input, 1, AHB direction (1 = write).
REQ-004 SHALL have port hreadyin, input, 1, AHB bus ready.
REQ-005 SHALL have port htrans, input, 2, AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-006 SHALL have port haddr, input, 32, AHB address.
REQ-007 SHALL have port hwdata, input, 32, AHB write data.
REQ-008 SHALL have port prdata, input, 32, APB read data.
REQ-009 SHALL have port valid, output, 1, qualified transfer request to the APB controller.
REQ-010 SHALL have ports haddr1 and haddr2, output, 32 each, haddr delayed by 1 and 2 cycles.
REQ-011 SHALL have ports hwdata1 and hwdata2, output, 32 each, hwdata delayed by 1 and 2 cycles.
REQ-012 SHALL have ports hwrite_reg and hwrite_reg1, output, 1 each, hwrite delayed by 1 and 2 cycles.
REQ-013 SHALL have port tempsel, output, 3, one-hot APB slave select decoded from haddr.
REQ-014 SHALL have port hrdata, output, 32, AHB read data.
REQ-015 SHALL have port hresp, output, 2, AHB response (00 OKAY, 01 ERROR).
REQ-016 SHALL have port err_hready, output, 1, ready contribution of this block (0 stalls the bus).

Function
REQ-017 SHALL decode tempsel combinationally from haddr: 0x8000_0000-0x83FF_FFFF -> 001; 0x8400_0000-0x87FF_FFFF -> 010; 0x8800_0000-0x8BFF_FFFF -> 100; any other address -> 000.
REQ-018 SHALL define an active transfer as hreadyin=1 and htrans in {10, 11}; IDLE and BUSY are never active.
REQ-019 SHALL drive valid combinationally: 1 only for an active transfer with tempsel != 000 while the error FSM is in OK.
REQ-020 SHALL register haddr1<=haddr, haddr2<=haddr1, hwdata1<=hwdata, hwdata2<=hwdata1, hwrite_reg<=hwrite and hwrite_reg1<=hwrite_reg every cycle, regardless of hreadyin, for fixed alignment with the APB controller.
REQ-021 SHALL drive hrdata combinationally equal to prdata, with zero latency.
REQ-022 SHALL implement a three-state error FSM: OK, ERR1, ERR2.
REQ-023 In OK: an active transfer with tempsel=000 -> ERR1; otherwise remain in OK.
REQ-024 ERR1 SHALL unconditionally go to ERR2, and ERR2 SHALL unconditionally go to OK.
REQ-025 SHALL decode Moore outputs from the state: OK -> hresp=00, err_hready=1; ERR1 -> hresp=01, err_hready=0; ERR2 -> hresp=01, err_hready=1.
REQ-026 SHALL ignore new transfers presented during ERR1/ERR2: valid=0 and no re-entry to ERR1; the master is required to drop to IDLE after ERROR.
REQ-027 Back-to-back active in-range transfers (SEQ) SHALL keep valid=1 on consecutive cycles, with no bubble inserted by this block.
REQ-028 An active transfer with hreadyin=0 SHALL yield valid=0 and no error, while pipeline registers still shift.

Reset
REQ-029 When hresetn=0 at a rising edge, SHALL clear haddr1, haddr2, hwdata1, hwdata2, hwrite_reg and hwrite_reg1 to 0 and set the FSM to OK.
REQ-030 While in reset state, outputs SHALL be hresp=00 and err_hready=1; valid and tempsel SHALL still follow their combinational inputs.
REQ-031 Reset asserted in ERR1 or ERR2 SHALL return to OK at that edge, with no completion of the ERROR response.

Verification
REQ-032 Reset: hresetn=0 for 2 cycles, hwdata=0xFFFF_FFFF -> hwdata1=hwdata2=0, hresp=00, err_hready=1.
REQ-033 Single write: htrans=10, hwrite=1, hreadyin=1, haddr=0x8400_0010, hwdata=0xA5A5_0001 -> valid=1 and tempsel=010 same cycle; next cycle haddr1=0x8400_0010, hwrite_reg=1; cycle after, haddr2=0x8400_0010, hwdata2=0xA5A5_0001.
REQ-034 Invalid address: htrans=10, haddr=0x9000_0000 -> valid=0, tempsel=000; next cycle hresp=01, err_hready=0; next hresp=01, err_hready=1; next hresp=00.
REQ-035 Qualification: htrans=01 or 00 at haddr=0x8000_0000, and htrans=10 with hreadyin=0 -> valid=0, hresp stays 00.
REQ-036 Burst: NONSEQ then SEQ at 0x8800_0000, 0x8800_0004, 0x8800_0008 -> valid=1 three consecutive cycles, tempsel=100, haddr1 trails haddr by one cycle.
REQ-037 Reset mid-error: hresetn=0 during ERR1 -> next cycle hresp=00, err_hready=1; prdata=0x1234_5678 -> hrdata=0x1234_5678 immediately.

Source files
------------

// File: rtl/ahb_slave_if.sv
// AHB slave-side front end for an AHB-to-APB bridge: qualifies transfers, decodes
// the APB slave select, aligns address/data/direction pipelines and signals ERROR.
module ahb_slave_if (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hwrite,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    output logic        valid,
    output logic [31:0] haddr1,
    output logic [31:0] haddr2,
    output logic [31:0] hwdata1,
    output logic [31:0] hwdata2,
    output logic        hwrite_reg,
    output logic        hwrite_reg1,
    output logic [2:0]  tempsel,
    output logic [31:0] hrdata,
    output logic [1:0]  hresp,
    output logic        err_hready
);

    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_t;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    err_state_t  state_q, state_d;
    logic [31:0] haddr1_q, haddr1_d;
    logic [31:0] haddr2_q, haddr2_d;
    logic [31:0] hwdata1_q, hwdata1_d;
    logic [31:0] hwdata2_q, hwdata2_d;
    logic        hwrite_reg_q, hwrite_reg_d;
    logic        hwrite_reg1_q, hwrite_reg1_d;

    logic [2:0]  tempsel_s;
    logic        active_s;
    logic        valid_s;
    logic [1:0]  hresp_s;
    logic        err_hready_s;

    // Slave select from the top six address bits: three 64 MiB windows at 0x80/0x84/0x88.
    always_comb begin
        tempsel_s = 3'b000;
        case (haddr[31:26])
            6'b100000: tempsel_s = 3'b001;
            6'b100001: tempsel_s = 3'b010;
            6'b100010: tempsel_s = 3'b100;
            default:   tempsel_s = 3'b000;
        endcase
    end

    // Transfer qualification; new requests are suppressed while an ERROR is in flight.
    always_comb begin
        active_s = 1'b0;
        valid_s  = 1'b0;
        if (hreadyin && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        if (active_s && (tempsel_s != 3'b000) && (state_q == ST_OK)) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Pipeline shifts every cycle so APB-side timing never depends on hreadyin.
    always_comb begin
        haddr1_d      = haddr;
        haddr2_d      = haddr1_q;
        hwdata1_d     = hwdata;
        hwdata2_d     = hwdata1_q;
        hwrite_reg_d  = hwrite;
        hwrite_reg1_d = hwrite_reg_q;
    end

    // Error FSM next state: a two-cycle ERROR response, first cycle stalling the bus.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OK: begin
                if (active_s && (tempsel_s == 3'b000)) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_OK;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_OK;
            default: state_d = ST_OK;
        endcase
    end

    // Moore response outputs decoded from the error state.
    always_comb begin
        hresp_s      = HRESP_OKAY;
        err_hready_s = 1'b1;
        case (state_q)
            ST_OK: begin
                hresp_s      = HRESP_OKAY;
                err_hready_s = 1'b1;
            end
            ST_ERR1: begin
                hresp_s      = HRESP_ERROR;
                err_hready_s = 1'b0;
            end
            ST_ERR2: begin
                hresp_s      = HRESP_ERROR;
                err_hready_s = 1'b1;
            end
            default: begin
                hresp_s      = HRESP_OKAY;
                err_hready_s = 1'b1;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q       <= ST_OK;
            haddr1_q      <= 32'h0000_0000;
            haddr2_q      <= 32'h0000_0000;
            hwdata1_q     <= 32'h0000_0000;
            hwdata2_q     <= 32'h0000_0000;
            hwrite_reg_q  <= 1'b0;
            hwrite_reg1_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            haddr1_q      <= haddr1_d;
            haddr2_q      <= haddr2_d;
            hwdata1_q     <= hwdata1_d;
            hwdata2_q     <= hwdata2_d;
            hwrite_reg_q  <= hwrite_reg_d;
            hwrite_reg1_q <= hwrite_reg1_d;
        end
    end

    assign valid       = valid_s;
    assign tempsel     = tempsel_s;
    assign hrdata      = prdata;
    assign hresp       = hresp_s;
    assign err_hready  = err_hready_s;
    assign haddr1      = haddr1_q;
    assign haddr2      = haddr2_q;
    assign hwdata1     = hwdata1_q;
    assign hwdata2     = hwdata2_q;
    assign hwrite_reg  = hwrite_reg_q;
    assign hwrite_reg1 = hwrite_reg1_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed self-checking bench for ahb_slave_if: reset, write pipeline, error
// response, qualification, burst, reset during error and read-data pass-through.
module tb_ahb_slave_if;

    logic        hclk;
    logic        hresetn;
    logic        hwrite;
    logic        hreadyin;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        valid;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata1;
    logic [31:0] hwdata2;
    logic        hwrite_reg;
    logic        hwrite_reg1;
    logic [2:0]  tempsel;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        err_hready;

    int checks = 0;
    int errors = 0;

    ahb_slave_if dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hwrite      (hwrite),
        .hreadyin    (hreadyin),
        .htrans      (htrans),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .prdata      (prdata),
        .valid       (valid),
        .haddr1      (haddr1),
        .haddr2      (haddr2),
        .hwdata1     (hwdata1),
        .hwdata2     (hwdata2),
        .hwrite_reg  (hwrite_reg),
        .hwrite_reg1 (hwrite_reg1),
        .tempsel     (tempsel),
        .hrdata      (hrdata),
        .hresp       (hresp),
        .err_hready  (err_hready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hresetn  = 1'b0;
        hwrite   = 1'b0;
        hreadyin = 1'b1;
        htrans   = 2'b00;
        haddr    = 32'h8000_0000;
        hwdata   = 32'hFFFF_FFFF;
        prdata   = 32'h0000_0000;

        // Reset for two cycles
        step();
        step();
        chk("rst_hwdata1", hwdata1, 32'h0);
        chk("rst_hwdata2", hwdata2, 32'h0);
        chk("rst_hresp", {30'h0, hresp}, 32'h0);
        chk("rst_err_hready", {31'h0, err_hready}, 32'h1);
        chk("rst_tempsel_comb", {29'h0, tempsel}, 32'h1);
        chk("rst_valid_idle", {31'h0, valid}, 32'h0);

        // Single write
        hresetn = 1'b1;
        htrans  = 2'b10;
        hwrite  = 1'b1;
        haddr   = 32'h8400_0010;
        hwdata  = 32'hA5A5_0001;
        #1;
        chk("wr_valid", {31'h0, valid}, 32'h1);
        chk("wr_tempsel", {29'h0, tempsel}, 32'h2);
        step();
        chk("wr_haddr1", haddr1, 32'h8400_0010);
        chk("wr_hwrite_reg", {31'h0, hwrite_reg}, 32'h1);
        chk("wr_hwdata1", hwdata1, 32'hA5A5_0001);
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0000_0000;
        hwdata = 32'h0000_0000;
        step();
        chk("wr_haddr2", haddr2, 32'h8400_0010);
        chk("wr_hwdata2", hwdata2, 32'hA5A5_0001);
        chk("wr_hwrite_reg1", {31'h0, hwrite_reg1}, 32'h1);
        chk("wr_hwrite_reg_clr", {31'h0, hwrite_reg}, 32'h0);

        // Invalid address -> two-cycle ERROR
        htrans = 2'b10;
        haddr  = 32'h9000_0000;
        #1;
        chk("inv_valid", {31'h0, valid}, 32'h0);
        chk("inv_tempsel", {29'h0, tempsel}, 32'h0);
        chk("inv_hresp_pre", {30'h0, hresp}, 32'h0);
        step();
        chk("err1_hresp", {30'h0, hresp}, 32'h1);
        chk("err1_hready", {31'h0, err_hready}, 32'h0);
        haddr = 32'h8000_0000;
        #1;
        chk("err1_valid_blocked", {31'h0, valid}, 32'h0);
        step();
        chk("err2_hresp", {30'h0, hresp}, 32'h1);
        chk("err2_hready", {31'h0, err_hready}, 32'h1);
        haddr = 32'h9000_0000;
        step();
        chk("err_done_hresp", {30'h0, hresp}, 32'h0);
        chk("err_done_hready", {31'h0, err_hready}, 32'h1);
        htrans = 2'b00;
        step();
        chk("err_no_reentry", {30'h0, hresp}, 32'h0);

        // Qualification
        haddr  = 32'h8000_0000;
        htrans = 2'b01;
        #1;
        chk("q_busy_valid", {31'h0, valid}, 32'h0);
        htrans = 2'b00;
        #1;
        chk("q_idle_valid", {31'h0, valid}, 32'h0);
        htrans   = 2'b10;
        hreadyin = 1'b0;
        #1;
        chk("q_notready_valid", {31'h0, valid}, 32'h0);
        step();
        chk("q_notready_hresp", {30'h0, hresp}, 32'h0);
        chk("q_notready_shift", haddr1, 32'h8000_0000);
        haddr = 32'h9000_0000;
        step();
        chk("q_notready_inv_hresp", {30'h0, hresp}, 32'h0);
        chk("q_notready_inv_hready", {31'h0, err_hready}, 32'h1);

        // Boundary decodes
        htrans = 2'b00;
        haddr  = 32'h8BFF_FFFC;
        #1;
        chk("dec_8bff", {29'h0, tempsel}, 32'h4);
        haddr = 32'h8C00_0000;
        #1;
        chk("dec_8c00", {29'h0, tempsel}, 32'h0);
        haddr = 32'h7FFF_FFFF;
        #1;
        chk("dec_7fff", {29'h0, tempsel}, 32'h0);
        haddr = 32'h83FF_FFFF;
        #1;
        chk("dec_83ff", {29'h0, tempsel}, 32'h1);

        // Burst NONSEQ + SEQ
        hreadyin = 1'b1;
        htrans   = 2'b10;
        haddr    = 32'h8800_0000;
        #1;
        chk("b0_valid", {31'h0, valid}, 32'h1);
        chk("b0_tempsel", {29'h0, tempsel}, 32'h4);
        step();
        htrans = 2'b11;
        haddr  = 32'h8800_0004;
        #1;
        chk("b1_valid", {31'h0, valid}, 32'h1);
        chk("b1_haddr1", haddr1, 32'h8800_0000);
        step();
        haddr = 32'h8800_0008;
        #1;
        chk("b2_valid", {31'h0, valid}, 32'h1);
        chk("b2_tempsel", {29'h0, tempsel}, 32'h4);
        chk("b2_haddr1", haddr1, 32'h8800_0004);
        step();
        htrans = 2'b00;
        chk("b3_haddr1", haddr1, 32'h8800_0008);
        chk("b3_haddr2", haddr2, 32'h8800_0004);
        chk("b3_hresp", {30'h0, hresp}, 32'h0);

        // Reset during ERR1
        htrans = 2'b10;
        haddr  = 32'hC000_0000;
        step();
        htrans = 2'b00;
        chk("rm_err1_hresp", {30'h0, hresp}, 32'h1);
        hresetn = 1'b0;
        step();
        chk("rm_hresp", {30'h0, hresp}, 32'h0);
        chk("rm_hready", {31'h0, err_hready}, 32'h1);
        chk("rm_haddr1", haddr1, 32'h0);
        prdata = 32'h1234_5678;
        #1;
        chk("rm_hrdata", hrdata, 32'h1234_5678);
        hresetn = 1'b1;
        step();
        chk("rm_after_hresp", {30'h0, hresp}, 32'h0);
        prdata = 32'hDEAD_BEEF;
        #1;
        chk("hrdata_pass", hrdata, 32'hDEAD_BEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
